// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : PC generator + DEPTH-entry instruction queue in front of decode
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC00000)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       inst_req,
  output logic [ADDR_W-1:0]          inst_addr,
  input  logic                       inst_addr_ok,
  input  logic                       inst_data_ok,
  input  logic [INST_W-1:0]          inst_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [ADDR_W-1:0]          deq_pc,
  output logic [INST_W-1:0]          deq_instr,
  output logic                       deq_adel,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              started_q;
  logic              halted_q, halted_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     if_wr_q, if_wr_d, if_rd_q, if_rd_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;

  logic [ADDR_W-1:0] if_pc_q [DEPTH];
  logic [ADDR_W-1:0] q_pc_q    [DEPTH];
  logic [INST_W-1:0] q_instr_q [DEPTH];
  logic              q_adel_q  [DEPTH];

  logic              credit, pc_aligned, fetch_ok;
  logic              accept, resp, live, adel_enq, enq, deq;
  logic [ADDR_W-1:0] enq_pc;
  logic [INST_W-1:0] enq_instr;

  // Queue entries plus requests still in flight must never exceed DEPTH.
  assign credit     = ({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign fetch_ok   = started_q & ~halted_q & ~redirect_valid & credit;

  assign inst_req  = fetch_ok & pc_aligned;
  assign inst_addr = pc_q;

  assign accept = inst_req & inst_addr_ok;
  assign resp   = inst_data_ok & (outst_q != '0);
  assign live   = resp & (discard_q == '0) & ~redirect_valid;
  // Only raise the address error once no live response is still owed, so it stays in order.
  assign adel_enq = fetch_ok & ~pc_aligned & (outst_q == discard_q);
  assign enq      = live | adel_enq;
  assign deq      = deq_valid & deq_ready & ~redirect_valid;

  assign enq_pc    = live ? if_pc_q[if_rd_q] : pc_q;
  assign enq_instr = live ? inst_rdata : '0;

  always_comb begin
    pc_d      = pc_q;
    halted_d  = halted_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    count_d   = count_q;
    if_wr_d   = if_wr_q;
    if_rd_d   = if_rd_q;
    head_d    = head_q;
    tail_d    = tail_q;

    if (accept) begin
      pc_d    = pc_q + ADDR_W'(4);
      if_wr_d = if_wr_q + PW'(1);
    end
    if (resp) if_rd_d = if_rd_q + PW'(1);

    if (accept && !resp)      outst_d = outst_q + CW'(1);
    else if (!accept && resp) outst_d = outst_q - CW'(1);

    if (resp && discard_q != '0) discard_d = discard_q - CW'(1);
    if (adel_enq) halted_d = 1'b1;

    if (enq) tail_d = tail_q + PW'(1);
    if (deq) head_d = head_q + PW'(1);
    if (enq && !deq)      count_d = count_q + CW'(1);
    else if (!enq && deq) count_d = count_q - CW'(1);

    // Every request still in flight after this edge returns stale data.
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      halted_d  = 1'b0;
      discard_d = outst_d;
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
      halted_q  <= 1'b0;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      if_wr_q   <= '0;
      if_rd_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      started_q <= 1'b1;
      halted_q  <= halted_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      if_wr_q   <= if_wr_d;
      if_rd_q   <= if_rd_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  // Storage needs no reset: every read is qualified by the pointer/count state.
  always_ff @(posedge clk) begin
    if (accept) if_pc_q[if_wr_q] <= pc_q;
    if (enq) begin
      q_pc_q[tail_q]    <= enq_pc;
      q_instr_q[tail_q] <= enq_instr;
      q_adel_q[tail_q]  <= adel_enq;
    end
  end

  assign deq_valid = (count_q != '0);
  assign deq_pc    = deq_valid ? q_pc_q[head_q]    : '0;
  assign deq_instr = deq_valid ? q_instr_q[head_q] : '0;
  assign deq_adel  = deq_valid & q_adel_q[head_q];
  assign count     = count_q;

`ifndef SYNTHESIS
  a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!rst)
    !(inst_data_ok && outst_q == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : directed vector bench with an in-order SRAM-like responder
// Revision       : 1.0
// ============================================================================
module tb_fetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } deq_vec_t;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic        deq_adel;
  logic [2:0]  count;

  logic        aok_en;
  logic        rsp_en;
  int          total;
  int          bad;
  int          cyc;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] acc_log   [$];

  assign inst_addr_ok = aok_en;

  fetch_queue #(
    .ADDR_W  (32),
    .INST_W  (32),
    .DEPTH   (4),
    .RESET_PC(32'hBFC00000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .deq_ready     (deq_ready),
    .deq_valid     (deq_valid),
    .deq_pc        (deq_pc),
    .deq_instr     (deq_instr),
    .deq_adel      (deq_adel),
    .count         (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: data_ok two edges after the accept, rdata = ~address, strictly in order.
  initial begin : memory
    logic        s_acc;
    logic        s_rsp;
    logic [31:0] s_addr;
    cyc          = 0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        pend_addr.delete();
        pend_due.delete();
        inst_data_ok = 1'b0;
      end else if (rsp_en && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        inst_data_ok = 1'b1;
        inst_rdata   = ~pend_addr[0];
      end else begin
        inst_data_ok = 1'b0;
      end
      #3;
      s_acc  = rst && inst_req && inst_addr_ok;
      s_rsp  = rst && inst_data_ok;
      s_addr = inst_addr;
      @(posedge clk);
      cyc++;
      if (rst) begin
        if (s_rsp) begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (s_acc) begin
          pend_addr.push_back(s_addr);
          pend_due.push_back(cyc + 1);
          acc_log.push_back(s_addr);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_deq(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (deq_valid) begin
        ok = 1'b1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s: deq_valid never rose got 0 expected 1", name);
  endtask

  task automatic wait_acc(input string name, input int n);
    for (int i = 0; i < 40; i++) begin
      if (acc_log.size() >= n) return;
      step();
    end
    total++;
    bad++;
    $display("FAIL %s: accepts got %0d expected %0d", name, acc_log.size(), n);
  endtask

  task automatic check_entry(input string name, input deq_vec_t v);
    bit ok;
    wait_deq(name, ok);
    if (ok) begin
      chk({name, "_pc"},    deq_pc,    v.pc);
      chk({name, "_instr"}, deq_instr, v.instr);
      chk({name, "_adel"},  {31'd0, deq_adel}, {31'd0, v.adel});
    end
  endtask

  task automatic do_reset(input logic aok, input logic rsp, input logic rdy);
    rst            = 1'b0;
    aok_en         = 1'b0;
    rsp_en         = 1'b0;
    deq_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) step();
    acc_log.delete();
    aok_en    = aok;
    rsp_en    = rsp;
    deq_ready = rdy;
    rst       = 1'b1;
  endtask

  deq_vec_t t1 [6];
  deq_vec_t v;

  initial begin : main
    total          = 0;
    bad            = 0;
    rst            = 1'b0;
    aok_en         = 1'b0;
    rsp_en         = 1'b0;
    deq_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    t1[0] = '{pc: 32'hBFC00000, instr: 32'h403FFFFF, adel: 1'b0};
    t1[1] = '{pc: 32'hBFC00004, instr: 32'h403FFFFB, adel: 1'b0};
    t1[2] = '{pc: 32'hBFC00008, instr: 32'h403FFFF7, adel: 1'b0};
    t1[3] = '{pc: 32'hBFC0000C, instr: 32'h403FFFF3, adel: 1'b0};
    t1[4] = '{pc: 32'hBFC00010, instr: 32'h403FFFEF, adel: 1'b0};
    t1[5] = '{pc: 32'hBFC00014, instr: 32'h403FFFEB, adel: 1'b0};

    // Reset state
    repeat (2) step();
    chk("rst_req",   {31'd0, inst_req},  32'd0);
    chk("rst_valid", {31'd0, deq_valid}, 32'd0);
    chk("rst_pc",    deq_pc,             32'd0);
    chk("rst_instr", deq_instr,          32'd0);
    chk("rst_adel",  {31'd0, deq_adel},  32'd0);
    chk("rst_count", {29'd0, count},     32'd0);

    // Streaming fetch: deq order and accepted addresses follow the table
    do_reset(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) check_entry($sformatf("stream%0d", i), t1[i]);
    chk("stream_naccept", {31'd0, acc_log.size() >= 4}, 32'd1);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      chk($sformatf("stream_addr%0d", i), acc_log[i], t1[i].pc);

    // Credit limit with decode stalled, then a single dequeue, then a flush
    do_reset(1'b1, 1'b1, 1'b0);
    repeat (15) step();
    chk("full_naccept", acc_log.size(),    32'd4);
    chk("full_req",     {31'd0, inst_req}, 32'd0);
    chk("full_count",   {29'd0, count},    32'd4);
    chk("full_headpc",  deq_pc,            32'hBFC00000);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("deq1_count",  {29'd0, count},    32'd3);
    chk("deq1_headpc", deq_pc,            32'hBFC00004);
    chk("deq1_req",    {31'd0, inst_req}, 32'd1);
    repeat (8) step();
    chk("refill_naccept", acc_log.size(),    32'd5);
    if (acc_log.size() >= 5) chk("refill_addr", acc_log[4], 32'hBFC00010);
    chk("refill_count",   {29'd0, count},    32'd4);
    chk("refill_req",     {31'd0, inst_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000000;
    deq_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    deq_ready      = 1'b0;
    chk("flush_count", {29'd0, count},     32'd0);
    chk("flush_valid", {31'd0, deq_valid}, 32'd0);

    // Redirect with three requests in flight: stale responses are dropped
    do_reset(1'b1, 1'b0, 1'b1);
    wait_acc("infl3", 3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80001000;
    rsp_en         = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("redir_count", {29'd0, count},     32'd0);
    chk("redir_valid", {31'd0, deq_valid}, 32'd0);
    v = '{pc: 32'h80001000, instr: 32'h7FFFEFFF, adel: 1'b0};
    check_entry("redir0", v);
    v = '{pc: 32'h80001004, instr: 32'h7FFFEFFB, adel: 1'b0};
    check_entry("redir1", v);

    // Misaligned redirect target: one address-error entry, fetch halted
    do_reset(1'b1, 1'b1, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80001002;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("adel_req%0d", i), {31'd0, inst_req}, 32'd0);
      step();
    end
    chk("adel_valid",   {31'd0, deq_valid}, 32'd1);
    chk("adel_pc",      deq_pc,             32'h80001002);
    chk("adel_instr",   deq_instr,          32'd0);
    chk("adel_flag",    {31'd0, deq_adel},  32'd1);
    chk("adel_count",   {29'd0, count},     32'd1);
    chk("adel_naccept", acc_log.size(),     32'd0);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("adel_drained", {29'd0, count},    32'd0);
    chk("halted_req",   {31'd0, inst_req}, 32'd0);
    step();
    chk("halted_req2",  {31'd0, inst_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80002000;
    step();
    redirect_valid = 1'b0;
    deq_ready      = 1'b1;
    v = '{pc: 32'h80002000, instr: 32'h7FFFDFFF, adel: 1'b0};
    check_entry("resume", v);
    chk("resume_naccept", {31'd0, acc_log.size() >= 1}, 32'd1);
    if (acc_log.size() >= 1) chk("resume_addr", acc_log[0], 32'h80002000);

    // addr_ok withheld: request and address held stable, then one accept
    do_reset(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10 && !inst_req; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_req%0d", i),  {31'd0, inst_req}, 32'd1);
      chk($sformatf("hold_addr%0d", i), inst_addr,         32'hBFC00000);
      step();
    end
    aok_en = 1'b1;
    step();
    aok_en = 1'b0;
    chk("hold_naccept", acc_log.size(),    32'd1);
    if (acc_log.size() >= 1) chk("hold_acc_addr", acc_log[0], 32'hBFC00000);
    chk("hold_next",    inst_addr,         32'hBFC00004);
    chk("hold_req_on",  {31'd0, inst_req}, 32'd1);

    // Asynchronous reset mid-burst with two responses outstanding
    do_reset(1'b1, 1'b0, 1'b0);
    wait_acc("burst3", 3);
    aok_en = 1'b0;
    rsp_en = 1'b1;
    step();
    rsp_en = 1'b0;
    step();
    chk("burst_count", {29'd0, count}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_req",   {31'd0, inst_req},  32'd0);
    chk("arst_valid", {31'd0, deq_valid}, 32'd0);
    chk("arst_pc",    deq_pc,             32'd0);
    chk("arst_instr", deq_instr,          32'd0);
    chk("arst_count", {29'd0, count},     32'd0);
    repeat (2) step();
    acc_log.delete();
    aok_en    = 1'b1;
    rsp_en    = 1'b1;
    deq_ready = 1'b1;
    rst       = 1'b1;
    step();
    chk("rel_count", {29'd0, count},    32'd0);
    step();
    chk("rel_req",   {31'd0, inst_req}, 32'd1);
    wait_acc("rel_acc", 1);
    if (acc_log.size() >= 1) chk("rel_addr", acc_log[0], 32'hBFC00000);

    repeat (10) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
